demo_scene_sequencer: RTL

// Frame-rate timeline controller for the VGA demo. It steps through a fixed list of

---
 rtl/demo_scene_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/demo_scene_sequencer.sv
// Frame-rate timeline controller: steps through a fixed scene list, driving layer
// enables and a global fade level that only ever change on the frame tick.
module demo_scene_sequencer #(
    parameter int NUM_SCENES  = 4,
    parameter int HOLD_FRAMES = 480,
    parameter int FADE_STEP   = 2
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       skip,
    input  logic       hold,
    output logic [1:0] scene,
    output logic [3:0] layer_en,
    output logic [5:0] fade,
    output logic [9:0] scene_frame,
    output logic       scene_change
);

    typedef enum logic [1:0] {
        S_FADE_IN  = 2'd0,
        S_HOLD     = 2'd1,
        S_FADE_OUT = 2'd2,
        S_BLACK    = 2'd3
    } state_t;

    localparam logic [6:0]        STEP7     = 7'(FADE_STEP);
    localparam logic signed [7:0] STEP8     = 8'(FADE_STEP);
    localparam logic [9:0]        HOLD_LAST = 10'(HOLD_FRAMES - 1);
    localparam logic [2:0]        NSC3      = 3'(NUM_SCENES);

    function automatic logic [3:0] layer_rom(input logic [1:0] s);
        case (s)
            2'd0:    layer_rom = 4'b0101;
            2'd1:    layer_rom = 4'b0110;
            2'd2:    layer_rom = 4'b0111;
            default: layer_rom = 4'b1111;
        endcase
    endfunction

    state_t      r_state, w_state_d;
    logic [9:0]  r_hold_cnt, w_hold_d;
    logic        r_skip_pend, w_skip_pend_d;
    logic [1:0]  r_scene, w_scene_d;
    logic [3:0]  r_layer, w_layer_d;
    logic [5:0]  r_fade, w_fade_d;
    logic [9:0]  r_sf, w_sf_d;
    logic        r_chg;

    logic              w_step;
    logic              w_skip_eff;
    logic              w_adv;
    logic [6:0]        w_up7;
    logic [5:0]        w_up;
    logic signed [7:0] w_dn8;
    logic [5:0]        w_dn;
    logic [2:0]        w_scene_inc;
    logic [1:0]        w_scene_wrap;

    // A tick with hold high freezes the timeline but still counts frames.
    assign w_step     = frame_tick & ~hold;
    assign w_skip_eff = r_skip_pend | skip;
    assign w_adv      = w_step & (r_state == S_BLACK);

    assign w_up7 = {1'b0, r_fade} + STEP7;
    assign w_up  = (w_up7 > 7'd63) ? 6'd63 : w_up7[5:0];
    assign w_dn8 = $signed({2'b00, r_fade}) - STEP8;
    assign w_dn  = (w_dn8 < 8'sd0) ? 6'd0 : w_dn8[5:0];

    assign w_scene_inc  = {1'b0, r_scene} + 3'd1;
    assign w_scene_wrap = (w_scene_inc == NSC3) ? 2'd0 : w_scene_inc[1:0];

    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold_cnt;
        w_fade_d  = r_fade;
        w_scene_d = r_scene;
        w_layer_d = r_layer;
        if (w_step) begin
            case (r_state)
                S_FADE_IN: begin
                    if (w_skip_eff) begin
                        w_state_d = S_FADE_OUT;
                    end else begin
                        w_fade_d = w_up;
                        if (w_up == 6'd63) begin
                            w_state_d = S_HOLD;
                            w_hold_d  = 10'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST || w_skip_eff)
                        w_state_d = S_FADE_OUT;
                    else
                        w_hold_d = r_hold_cnt + 10'd1;
                end
                S_FADE_OUT: begin
                    w_fade_d = w_dn;
                    if (w_dn == 6'd0)
                        w_state_d = S_BLACK;
                end
                default: begin
                    w_fade_d  = 6'd0;
                    w_scene_d = w_scene_wrap;
                    w_layer_d = layer_rom(w_scene_wrap);
                    w_state_d = S_FADE_IN;
                end
            endcase
        end
    end

    // Every non-held tick consumes (or drops) a pending skip; otherwise skips accumulate.
    always_comb begin
        w_skip_pend_d = r_skip_pend | skip;
        if (w_step)
            w_skip_pend_d = 1'b0;
    end

    always_comb begin
        w_sf_d = r_sf;
        if (frame_tick) begin
            if (w_adv)
                w_sf_d = 10'd0;
            else if (r_sf != 10'd1023)
                w_sf_d = r_sf + 10'd1;
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FADE_IN;
            r_hold_cnt  <= 10'd0;
            r_skip_pend <= 1'b0;
            r_scene     <= 2'd0;
            r_layer     <= 4'b0101;
            r_fade      <= 6'd0;
            r_sf        <= 10'd0;
            r_chg       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_hold_cnt  <= w_hold_d;
            r_skip_pend <= w_skip_pend_d;
            r_scene     <= w_scene_d;
            r_layer     <= w_layer_d;
            r_fade      <= w_fade_d;
            r_sf        <= w_sf_d;
            r_chg       <= w_adv;
        end
    end

    assign scene        = r_scene;
    assign layer_en     = r_layer;
    assign fade         = r_fade;
    assign scene_frame  = r_sf;
    assign scene_change = r_chg;

endmodule
